// File: rtl/data_mem_resp_if.sv
// Request/response channel between the memory-access stage (master) and the
// data memory responder (slave).
interface data_mem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Word-addressed data memory with a programmable wait-state count, a single
// outstanding access and a one-cycle response pulse with error flag.
module data_mem_resp #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic           clk,
  input logic           reset,
  data_mem_resp_if.slave bus
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic        latchWe_q;
  logic [31:0] latchAddr_q;
  logic [31:0] latchWdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH];

  logic             reqReady;
  logic             respValid;
  logic             accWe;
  logic [31:0]      accAddr;
  logic [31:0]      accWdata;
  logic             accErr;
  logic [IDX_W-1:0] accIdx;
  logic             commit;

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    reqReady  = 1'b0;
    respValid = 1'b0;
    case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (bus.req_valid) begin
          if (LATENCY > 0) begin
            state_d   = WAIT;
            waitCnt_d = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (waitCnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      RESP: begin
        respValid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so the
  // access must come straight from the bus instead of the latches.
  always_comb begin
    accWe    = latchWe_q;
    accAddr  = latchAddr_q;
    accWdata = latchWdata_q;
    if (state_q == IDLE) begin
      accWe    = bus.req_we;
      accAddr  = bus.req_addr;
      accWdata = bus.req_wdata;
    end
    accErr = (accAddr[1:0] != 2'b00) || (accAddr >= ADDR_LIMIT);
    accIdx = accAddr[IDX_W+1:2];
    commit = (state_d == RESP) && (state_q != RESP) && !reset;
  end

  // Control state, request latches and the held response values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      waitCnt_q    <= 4'd0;
      latchWe_q    <= 1'b0;
      latchAddr_q  <= 32'd0;
      latchWdata_q <= 32'd0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      if ((state_q == IDLE) && bus.req_valid) begin
        latchWe_q    <= bus.req_we;
        latchAddr_q  <= bus.req_addr;
        latchWdata_q <= bus.req_wdata;
      end
      if (commit) begin
        err_q   <= accErr;
        rdata_q <= (!accWe && !accErr) ? mem_q[accIdx] : 32'd0;
      end
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (commit && accWe && !accErr) begin
      mem_q[accIdx] <= accWdata;
    end
  end

  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = respValid;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench: one responder with two wait states (A) and one with
// none (B), compared against an associative-array model of the memory.
module tb_data_mem_resp;

  localparam int DEPTH = 1024;
  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_resp_if ifA ();
  data_mem_resp_if ifB ();

  data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dutA (.clk(clk), .reset(reset), .bus(ifA));
  data_mem_resp #(.DEPTH(DEPTH), .LATENCY(0))     dutB (.clk(clk), .reset(reset), .bus(ifB));

  int nCompared;
  int nMismatched;

  logic [31:0] modelA [int unsigned];
  logic [31:0] modelB [int unsigned];

  // Reference behaviour: errors from the address rules, words kept by index.
  function automatic void predict(input bit sel, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] expRd,
                                  output logic expE, output bit known);
    int unsigned idx;
    idx   = addr >> 2;
    expE  = ((addr & 32'h3) != 32'd0) || (addr >= 32'(4 * DEPTH));
    expRd = 32'd0;
    known = 1'b1;
    if (!expE) begin
      if (we) begin
        if (sel) modelB[idx] = wdata;
        else     modelA[idx] = wdata;
      end else if (sel) begin
        if (modelB.exists(idx)) expRd = modelB[idx];
        else known = 1'b0;
      end else begin
        if (modelA.exists(idx)) expRd = modelA[idx];
        else known = 1'b0;
      end
    end
  endfunction

  // One access on A; inputs are scrambled while it waits to prove they are latched.
  task automatic accessA(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err);
    int waited;
    @(negedge clk);
    waited = 0;
    while (!ifA.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ifA.req_valid = 1'b1;
    ifA.req_we    = we;
    ifA.req_addr  = addr;
    ifA.req_wdata = wdata;
    @(negedge clk);
    ifA.req_valid = 1'b0;
    ifA.req_we    = ~we;
    ifA.req_addr  = addr ^ 32'h4;
    ifA.req_wdata = ~wdata;
    lat = 1;
    while (!ifA.resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!ifA.resp_valid) lat = -1;
    rdata = ifA.resp_rdata;
    err   = ifA.resp_err;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    nCompared += 6;
    if (ifA.req_ready !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL resetReadyA: got %b want 1", ifA.req_ready);
    end
    if (ifA.resp_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL resetValidA: got %b want 0", ifA.resp_valid);
    end
    if (ifA.resp_rdata !== 32'd0) begin
      nMismatched++; $display("[TB] FAIL resetRdataA: got %h want 0", ifA.resp_rdata);
    end
    if (ifA.resp_err !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL resetErrA: got %b want 0", ifA.resp_err);
    end
    if (ifB.req_ready !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL resetReadyB: got %b want 1", ifB.req_ready);
    end
    if (ifB.resp_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL resetValidB: got %b want 0", ifB.resp_valid);
    end
    reset = 1'b0;
  endtask

  // Runs a fixed list of accesses on A and compares each with the model.
  task automatic test_sequence(input string name, input int n, input logic weL [8],
                               input logic [31:0] addrL [8], input logic [31:0] dataL [8]);
    int lat;
    logic [31:0] rd, expRd;
    logic er, expE;
    bit known;
    for (int i = 0; i < n; i++) begin
      accessA(weL[i], addrL[i], dataL[i], lat, rd, er);
      predict(1'b0, weL[i], addrL[i], dataL[i], expRd, expE, known);
      nCompared += 2;
      if (lat !== LAT_A + 1) begin
        nMismatched++; $display("[TB] FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, LAT_A + 1);
      end
      if (er !== expE) begin
        nMismatched++; $display("[TB] FAIL %s[%0d] err: got %b want %b", name, i, er, expE);
      end
      if (known) begin
        nCompared++;
        if (rd !== expRd) begin
          nMismatched++; $display("[TB] FAIL %s[%0d] rdata: got %h want %h", name, i, rd, expRd);
        end
      end
    end
  endtask

  task automatic test_store_load();
    logic weL [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] addrL [8] = '{32'h10, 32'h10, 0, 0, 0, 0, 0, 0};
    logic [31:0] dataL [8] = '{32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 0, 0};
    test_sequence("storeLoad", 2, weL, addrL, dataL);
  endtask

  task automatic test_misaligned();
    logic weL [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    logic [31:0] addrL [8] = '{32'h12, 32'h10, 32'h13, 32'h10, 0, 0, 0, 0};
    logic [31:0] dataL [8] = '{32'h1, 32'h0, 32'h77, 32'h0, 0, 0, 0, 0};
    test_sequence("misaligned", 4, weL, addrL, dataL);
  endtask

  task automatic test_range();
    logic weL [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
    logic [31:0] addrL [8] = '{32'hFFC, 32'hFFC, 32'h1000, 32'h0, 32'h1000, 32'h0,
                               32'hFFFFFFFC, 32'hFFFFFFFC};
    logic [31:0] dataL [8] = '{32'hCAFE0FFC, 0, 0, 32'h00A11A5, 32'hBAD0BAD0, 0, 0, 32'h12345678};
    test_sequence("range", 8, weL, addrL, dataL);
  endtask

  task automatic test_latched_inputs();
    logic weL [8] = '{1, 1, 0, 0, 0, 1, 0, 0};
    logic [31:0] addrL [8] = '{32'h34, 32'h30, 32'h34, 32'h30, 32'h30, 32'h38, 32'h3C, 32'h38};
    logic [31:0] dataL [8];
    for (int i = 0; i < 8; i++) dataL[i] = $urandom;
    test_sequence("latched", 8, weL, addrL, dataL);
  endtask

  task automatic test_reset_during_wait(input int holdCycles);
    int lat, seen;
    logic [31:0] rd, expRd;
    logic er, expE;
    bit known;
    logic [31:0] pre;
    pre = $urandom;
    accessA(1'b1, 32'h20, pre, lat, rd, er);
    predict(1'b0, 1'b1, 32'h20, pre, expRd, expE, known);
    @(negedge clk);
    ifA.req_valid = 1'b1;
    ifA.req_we    = 1'b1;
    ifA.req_addr  = 32'h20;
    ifA.req_wdata = 32'h55;
    @(negedge clk);
    ifA.req_valid = 1'b0;
    repeat (holdCycles - 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nCompared += 2;
    if (ifA.req_ready !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL abort%0d ready: got %b want 1", holdCycles, ifA.req_ready);
    end
    if (ifA.resp_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL abort%0d valid: got %b want 0", holdCycles, ifA.resp_valid);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ifA.resp_valid) seen++;
    end
    nCompared++;
    if (seen !== 0) begin
      nMismatched++; $display("[TB] FAIL abort%0d strayPulses: got %0d want 0", holdCycles, seen);
    end
    accessA(1'b0, 32'h20, 32'h0, lat, rd, er);
    nCompared += 2;
    if (rd !== pre) begin
      nMismatched++; $display("[TB] FAIL abort%0d reload: got %h want %h", holdCycles, rd, pre);
    end
    if (lat !== LAT_A + 1) begin
      nMismatched++; $display("[TB] FAIL abort%0d latency: got %0d want %0d", holdCycles, lat, LAT_A + 1);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] addr, wdata, rd, expRd;
    logic we, er, expE;
    bit known;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: addr = 32'($urandom_range(0, 15)) << 2;
        3:       addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        4:       addr = 32'hFFC;
        5:       addr = 32'h1000;
        6:       addr = 32'hFFFFFFFC;
        default: addr = $urandom;
      endcase
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      accessA(we, addr, wdata, lat, rd, er);
      predict(1'b0, we, addr, wdata, expRd, expE, known);
      nCompared += 2;
      if (lat !== LAT_A + 1) begin
        nMismatched++; $display("[TB] FAIL random[%0d] latency: got %0d want %0d", i, lat, LAT_A + 1);
      end
      if (er !== expE) begin
        nMismatched++; $display("[TB] FAIL random[%0d] err @%h: got %b want %b", i, addr, er, expE);
      end
      if (known) begin
        nCompared++;
        if (rd !== expRd) begin
          nMismatched++; $display("[TB] FAIL random[%0d] rdata @%h: got %h want %h", i, addr, rd, expRd);
        end
      end
    end
  endtask

  // B has no wait states: with req_valid held high, accepts land every other cycle.
  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    for (int i = 0; i < 3; i++) begin
      addrs[i] = 32'(i * 64) + (32'($urandom_range(0, 15)) << 2);
      datas[i] = $urandom;
    end
    for (int batch = 0; batch < 2; batch++) begin
      int nextOp, accCycle, nResp;
      bit acceptedLast, known;
      logic [31:0] pendRd;
      logic pendE;
      nextOp = 0; accCycle = -10; nResp = 0; acceptedLast = 1'b0;
      pendRd = 32'd0; pendE = 1'b0;
      @(negedge clk);
      ifB.req_valid = 1'b1;
      ifB.req_we    = (batch == 0);
      ifB.req_addr  = addrs[0];
      ifB.req_wdata = datas[0];
      for (int c = 0; c < 10; c++) begin
        if (c > 0) @(negedge clk);
        if (acceptedLast) begin
          acceptedLast = 1'b0;
          nextOp++;
          if (nextOp < 3) begin
            ifB.req_addr  = addrs[nextOp];
            ifB.req_wdata = datas[nextOp];
          end else begin
            ifB.req_valid = 1'b0;
          end
        end
        nCompared += 2;
        if (ifB.req_ready !== (accCycle != c - 1)) begin
          nMismatched++; $display("[TB] FAIL b2b%0d ready c%0d: got %b want %b", batch, c, ifB.req_ready, accCycle != c - 1);
        end
        if (ifB.resp_valid !== (accCycle == c - 1)) begin
          nMismatched++; $display("[TB] FAIL b2b%0d valid c%0d: got %b want %b", batch, c, ifB.resp_valid, accCycle == c - 1);
        end
        if (ifB.resp_valid === 1'b1 && accCycle == c - 1) begin
          nResp++;
          nCompared += 2;
          if (ifB.resp_err !== pendE) begin
            nMismatched++; $display("[TB] FAIL b2b%0d err c%0d: got %b want %b", batch, c, ifB.resp_err, pendE);
          end
          if (ifB.resp_rdata !== pendRd) begin
            nMismatched++; $display("[TB] FAIL b2b%0d rdata c%0d: got %h want %h", batch, c, ifB.resp_rdata, pendRd);
          end
        end
        if (ifB.req_valid && ifB.req_ready) begin
          nCompared++;
          if (c !== 2 * nextOp) begin
            nMismatched++; $display("[TB] FAIL b2b%0d acceptCycle op%0d: got %0d want %0d", batch, nextOp, c, 2 * nextOp);
          end
          accCycle     = c;
          acceptedLast = 1'b1;
          predict(1'b1, ifB.req_we, ifB.req_addr, ifB.req_wdata, pendRd, pendE, known);
        end
      end
      nCompared += 2;
      if (nextOp !== 3) begin
        nMismatched++; $display("[TB] FAIL b2b%0d accepted: got %0d want 3", batch, nextOp);
      end
      if (nResp !== 3) begin
        nMismatched++; $display("[TB] FAIL b2b%0d responses: got %0d want 3", batch, nResp);
      end
    end
  endtask

  initial begin
    nCompared     = 0;
    nMismatched   = 0;
    reset         = 1'b1;
    ifA.req_valid = 1'b0;
    ifA.req_we    = 1'b0;
    ifA.req_addr  = 32'd0;
    ifA.req_wdata = 32'd0;
    ifB.req_valid = 1'b0;
    ifB.req_we    = 1'b0;
    ifB.req_addr  = 32'd0;
    ifB.req_wdata = 32'd0;
    test_reset();
    test_store_load();
    test_misaligned();
    test_range();
    test_latched_inputs();
    test_reset_during_wait(1);
    test_reset_during_wait(2);
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
